// File: rtl/secded32_pkg.sv
// Shared types and check-bit generation for the 32-bit SEC code consumed by the c499 corrector.
package secded32_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CW_W   = DATA_W + CHK_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  check;
    } codeword_t;

    // Each mask selects the data bits whose XOR forms one check bit (group term plus byte/nibble terms).
    localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
        32'h00FF_1111, 32'hFF00_2222, 32'h0F0F_4444, 32'hF0F0_8888,
        32'h1111_00FF, 32'h2222_FF00, 32'h4444_0F0F, 32'h8888_F0F0
    };

    function automatic logic [CHK_W-1:0] calc_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = '0;
        for (int i = 0; i < CHK_W; i++) begin
            chk[i] = ^(data & CHK_MASK[i]);
        end
        return chk;
    endfunction

endpackage

// File: rtl/secded32_encoder_cw_fifo.sv
// Synchronous codeword FIFO with registered full/empty flags; DEPTH must be a power of two.
module cw_fifo
    import secded32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  codeword_t wdata_i,
    input  logic      pop_i,
    output codeword_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    codeword_t       mem_d [DEPTH];
    codeword_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_d, wr_ptr_q;
    logic [AW-1:0]   rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]   count_d, count_q;
    logic            full_d, full_q;
    logic            empty_d, empty_q;
    logic            do_push_s, do_pop_s;

    assign do_push_s = push_i & ~full_q;
    assign do_pop_s  = pop_i & ~empty_q;

    // Next-state for storage, pointers, occupancy and flags.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata_i;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        wr_ptr_d = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/secded32_encoder.sv
// Streaming SEC encoder: 32-bit words in, 40-bit codewords out through a small FIFO.
// Optional single-bit fault injection is built when ERR_INJECT_EN is defined.
module secded32_encoder
    import secded32_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [7:0]        out_check,
    output logic              out_chk_en,
    output logic [CNT_W-1:0]  word_cnt,
    input  logic              cnt_clr
`ifdef ERR_INJECT_EN
    ,
    input  logic              inj_arm,
    input  logic [5:0]        inj_bit,
    output logic              inj_done
`endif
);

    logic             push_s, pop_s;
    logic             fifo_full_s, fifo_empty_s;
    codeword_t        enc_cw_s, fifo_cw_s;
    logic [CNT_W-1:0] word_cnt_d, word_cnt_q;

    assign push_s = in_valid & ~fifo_full_s;
    assign pop_s  = out_ready & ~fifo_empty_s;

`ifdef ERR_INJECT_EN
    logic        inj_armed_d, inj_armed_q;
    logic [5:0]  inj_idx_d, inj_idx_q;
    logic        inj_done_d, inj_done_q;
    logic        arm_ok_s, inj_hit_s;
    logic [5:0]  eff_idx_s;
    logic [31:0] flip_data_s;
    logic [7:0]  flip_chk_s;

    // A same-cycle arm takes effect immediately, so it overrides the stored index for this push.
    always_comb begin
        arm_ok_s    = inj_arm & (inj_bit < 6'd40);
        eff_idx_s   = arm_ok_s ? inj_bit : inj_idx_q;
        inj_hit_s   = push_s & (arm_ok_s | inj_armed_q);
        flip_data_s = 32'd0;
        flip_chk_s  = 8'd0;
        if (eff_idx_s < 6'd32) begin
            flip_data_s = 32'd1 << eff_idx_s;
        end else begin
            flip_chk_s = 8'd1 << (eff_idx_s - 6'd32);
        end
        inj_idx_d   = eff_idx_s;
        inj_armed_d = (arm_ok_s | inj_armed_q) & ~push_s;
        inj_done_d  = inj_hit_s;
    end

    // Injection state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_armed_q <= 1'b0;
            inj_idx_q   <= 6'd0;
            inj_done_q  <= 1'b0;
        end else begin
            inj_armed_q <= inj_armed_d;
            inj_idx_q   <= inj_idx_d;
            inj_done_q  <= inj_done_d;
        end
    end

    assign inj_done = inj_done_q;
`endif

    // Codeword formation; any injected flip is applied after check generation.
    always_comb begin
        enc_cw_s.data  = in_data;
        enc_cw_s.check = calc_check(in_data);
`ifdef ERR_INJECT_EN
        if (inj_hit_s) begin
            enc_cw_s.data  = in_data ^ flip_data_s;
            enc_cw_s.check = calc_check(in_data) ^ flip_chk_s;
        end else begin
            enc_cw_s.data  = in_data;
        end
`endif
    end

    cw_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_cw_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (enc_cw_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_cw_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Accepted-word counter: clear wins over increment, increment saturates.
    always_comb begin
        if (cnt_clr) begin
            word_cnt_d = '0;
        end else if (push_s && (word_cnt_q != {CNT_W{1'b1}})) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt   = word_cnt_q;
    assign in_ready   = ~fifo_full_s;
    assign out_valid  = ~fifo_empty_s;
    assign out_chk_en = ~fifo_empty_s;
    assign out_data   = fifo_empty_s ? 32'd0 : fifo_cw_s.data;
    assign out_check  = fifo_empty_s ? 8'd0  : fifo_cw_s.check;

endmodule

// File: tb/tb_secded32_encoder.sv
// Self-checking bench for secded32_encoder; define ERR_INJECT_EN to also cover fault injection.
module tb_secded32_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic        out_chk_en;
    logic [3:0]  word_cnt;
    logic        cnt_clr;
`ifdef ERR_INJECT_EN
    logic        inj_arm;
    logic [5:0]  inj_bit;
    logic        inj_done;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    secded32_encoder #(
        .OUT_DEPTH (2),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_check  (out_check),
        .out_chk_en (out_chk_en),
        .word_cnt   (word_cnt),
        .cnt_clr    (cnt_clr)
`ifdef ERR_INJECT_EN
        ,
        .inj_arm    (inj_arm),
        .inj_bit    (inj_bit),
        .inj_done   (inj_done)
`endif
    );

    // Reference check bits straight from the G/X parity rules.
    function automatic bit xr(input logic [31:0] d, input int i, input int j);
        bit r = 1'b0;
        for (int k = i; k <= j; k++) r ^= d[k];
        return r;
    endfunction

    function automatic bit gg(input logic [31:0] d, input int a);
        return d[a] ^ d[a+4] ^ d[a+8] ^ d[a+12];
    endfunction

    function automatic logic [7:0] model_check(input logic [31:0] d);
        logic [7:0] c;
        c[0] = gg(d, 0)  ^ xr(d, 16, 23);
        c[1] = gg(d, 1)  ^ xr(d, 24, 31);
        c[2] = gg(d, 2)  ^ xr(d, 16, 19) ^ xr(d, 24, 27);
        c[3] = gg(d, 3)  ^ xr(d, 20, 23) ^ xr(d, 28, 31);
        c[4] = gg(d, 16) ^ xr(d, 0, 7);
        c[5] = gg(d, 17) ^ xr(d, 8, 15);
        c[6] = gg(d, 18) ^ xr(d, 0, 3)   ^ xr(d, 8, 11);
        c[7] = gg(d, 19) ^ xr(d, 4, 7)   ^ xr(d, 12, 15);
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; cnt_clr = 1'b0;
`ifdef ERR_INJECT_EN
        inj_arm = 1'b0; inj_bit = 6'd0;
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 || out_check !== 8'd0
            || out_chk_en !== 1'b0 || word_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b ready=%b data=%h chk=%h en=%b cnt=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_data, out_check, out_chk_en, word_cnt);
        end
`ifdef ERR_INJECT_EN
        n_tests++;
        if (inj_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_inj_done: got %b want 0", inj_done);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_known();
        logic [31:0] vec [4] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [7:0]  exp [4] = '{8'h00, 8'h51, 8'h8A, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vec[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || out_chk_en !== 1'b1 || out_data !== vec[i] || out_check !== exp[i]) begin
                n_fail++;
                $display("FAIL known[%0d]: valid=%b en=%b data=%h chk=%h, want 1 1 %h %h",
                         i, out_valid, out_chk_en, out_data, out_check, vec[i], exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = $urandom();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = w[0];
        @(negedge clk);
        in_data = w[1];
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== w[0]) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b ready=%b data=%h, want 1 1 %h", out_valid, in_ready, out_data, w[0]);
        end
        @(negedge clk);
        in_data = w[2];
        n_tests++;
        if (in_ready !== 1'b0 || out_data !== w[0]) begin
            n_fail++;
            $display("FAIL b2b_full: ready=%b data=%h, want 0 %h", in_ready, out_data, w[0]);
        end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== w[0] || out_check !== model_check(w[0])) begin
            n_fail++;
            $display("FAIL b2b_hold: ready=%b valid=%b data=%h chk=%h, want 0 1 %h %h",
                     in_ready, out_valid, out_data, out_check, w[0], model_check(w[0]));
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_data !== w[1] || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h ready=%b, want %h 1", out_data, in_ready, w[1]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== w[2]) begin
            n_fail++;
            $display("FAIL b2b_third: valid=%b data=%h, want 1 %h", out_valid, out_data, w[2]);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] exp;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_spurious: data=%h emitted with no word queued", out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp || out_check !== model_check(exp) || out_chk_en !== 1'b1) begin
                        n_fail++;
                        $display("FAIL random[%0d]: data=%h chk=%h en=%b, want %h %h 1",
                                 got, out_data, out_check, out_chk_en, exp, model_check(exp));
                    end
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(in_data);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (got != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL random_complete: delivered %0d left %0d, want 1000 0", got, q.size());
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        n_tests++;
        if (word_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_clear: got %0d want 0", word_cnt);
        end
        in_valid = 1'b1; in_data = $urandom();
        repeat (3) @(negedge clk);
        n_tests++;
        if (word_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL cnt_three: got %0d want 3", word_cnt);
        end
        repeat (14) @(negedge clk);
        n_tests++;
        if (word_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0d want 15", word_cnt);
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (word_cnt !== 4'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_clr_push: cnt=%0d valid=%b, want 0 1", word_cnt, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom();
        @(negedge clk);
        in_data = $urandom();
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_setup: valid=%b ready=%b, want 1 0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== 4'd0 || out_check !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_async: valid=%b ready=%b cnt=%0d chk=%h, want 0 1 0 00",
                     out_valid, in_ready, word_cnt, out_check);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after[%0d]: valid=%b data=%h, want 0", i, out_valid, out_data);
            end
        end
    endtask

`ifdef ERR_INJECT_EN
    task automatic test_inject();
        logic [31:0] d;
        out_ready = 1'b1;
        @(negedge clk);
        inj_arm = 1'b1; inj_bit = 6'd35;
        @(negedge clk);
        inj_arm = 1'b0; in_valid = 1'b1; in_data = 32'd0;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_check !== 8'h08 || out_data !== 32'd0 || inj_done !== 1'b1) begin
            n_fail++;
            $display("FAIL inj_check35: chk=%h data=%h done=%b, want 08 0 1", out_check, out_data, inj_done);
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd0;
        n_tests++;
        if (inj_done !== 1'b0) begin
            n_fail++;
            $display("FAIL inj_done_pulse: got %b want 0", inj_done);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_check !== 8'h00 || out_data !== 32'd0 || inj_done !== 1'b0) begin
            n_fail++;
            $display("FAIL inj_clean_next: chk=%h data=%h done=%b, want 00 0 0", out_check, out_data, inj_done);
        end
        // Out-of-range arm is ignored.
        @(negedge clk);
        inj_arm = 1'b1; inj_bit = 6'd45;
        @(negedge clk);
        d = $urandom();
        inj_arm = 1'b0; in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_data !== d || out_check !== model_check(d) || inj_done !== 1'b0) begin
            n_fail++;
            $display("FAIL inj_ignore45: data=%h chk=%h done=%b, want %h %h 0",
                     out_data, out_check, inj_done, d, model_check(d));
        end
        // Re-arm overwrites, then arm+push in the same cycle flips a data bit.
        @(negedge clk);
        inj_arm = 1'b1; inj_bit = 6'd10;
        @(negedge clk);
        inj_bit = 6'd33;
        @(negedge clk);
        inj_arm = 1'b0; in_valid = 1'b1; in_data = 32'd0;
        @(negedge clk);
        inj_arm = 1'b1; inj_bit = 6'd3; in_data = 32'd0;
        n_tests++;
        if (out_data !== 32'd0 || out_check !== 8'h02) begin
            n_fail++;
            $display("FAIL inj_overwrite: data=%h chk=%h, want 0 02", out_data, out_check);
        end
        @(negedge clk);
        inj_arm = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_data !== 32'h0000_0008 || out_check !== 8'h00 || inj_done !== 1'b1) begin
            n_fail++;
            $display("FAIL inj_same_cycle: data=%h chk=%h done=%b, want 00000008 00 1",
                     out_data, out_check, inj_done);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_back_to_back();
        test_random();
        test_counter();
`ifdef ERR_INJECT_EN
        test_inject();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
